imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_e      : loader FSM state encoding (CSUM exists only when the
//                  checksum feature is built in)
//   CSUM_SEED    : starting value of the running XOR checksum
//   imem_depth() : instruction-memory depth in words for a size in KB
//   imem_aw()    : word-address width for a size in KB
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam int CSUM_SEED = 0;

    // 1 KB of 32-bit words is 256 entries.
    function automatic int imem_depth(input int size_in_kb);
        return size_in_kb * 256;
    endfunction

    function automatic int imem_aw(input int size_in_kb);
        return $clog2(size_in_kb * 256);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Streams a length-prefixed image into instruction memory and then releases
// the downstream core from reset.
//
// Stream format: one length word N, then N payload words, then (checksum
// build only) one XOR checksum word covering the N payload words.
//
// Handshake: a word moves on a rising clk edge where s_valid && s_ready.
// s_valid/s_data come from upstream and may toggle freely; s_ready depends
// only on the current state (high in LEN, LOAD, CSUM), never on s_valid.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle load request (honoured in IDLE, DONE, ERR)
//   s_valid/s_data : upstream word stream, s_ready back-pressure
//   imem_we/waddr/wdata : registered instruction-memory write port
//   core_arst_n    : registered active-low core reset, high only in DONE
//   busy/done/err  : registered status flags
//   dbg_state      : current FSM state for observation
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to add checksum verification.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  IMEM_SZ_IN_KB = 1,
    localparam int DEPTH         = imem_depth(IMEM_SZ_IN_KB),
    localparam int AW            = imem_aw(IMEM_SZ_IN_KB)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [AW-1:0]         imem_waddr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_arst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output state_e                dbg_state
);

    localparam logic [DATA_WIDTH-1:0] DEPTH_D = DATA_WIDTH'(DEPTH);
    localparam logic [AW:0]           CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_e state_q, state_d;

    // Counters are AW+1 bits wide so that N == DEPTH is representable.
    logic [AW:0] len_q;
    logic [AW:0] cnt_q;
    logic [AW:0] cnt_inc;

    logic beat;
    logic len_zero;
    logic len_too_big;
    logic last_beat;

    logic busy_d, done_d, err_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
`endif

    assign beat        = s_valid && s_ready;
    assign cnt_inc     = cnt_q + CNT_ONE;
    assign len_zero    = (s_data == '0);
    assign len_too_big = (s_data > DEPTH_D);
    assign last_beat   = (cnt_inc == len_q);
    assign dbg_state   = state_q;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LEN;
            end
            LEN: begin
                if (beat) begin
                    if (len_zero)         state_d = DONE;
                    else if (len_too_big) state_d = ERR;
                    else                  state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat && last_beat) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (beat) state_d = (s_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // s_ready follows the current state; the status flags are decoded from
    // the next state so their registered copies line up with state_q.
    always_comb begin
        s_ready = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            LEN, LOAD:  s_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:       s_ready = 1'b1;
`endif
            default:    s_ready = 1'b0;
        endcase
        unique case (state_d)
            LEN, LOAD:  busy_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:       busy_d = 1'b1;
`endif
            DONE:       done_d = 1'b1;
            ERR:        err_d  = 1'b1;
            default:    busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            core_arst_n <= 1'b0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            core_arst_n <= done_d;
        end
    end

    // ---------------------------------------------------------------- datapath
    // Each payload beat becomes exactly one write on the following cycle.
    // Address/data hold their last value when no write is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (state_q == LEN && beat) begin
                len_q <= s_data[AW:0];
                cnt_q <= '0;
            end
            if (state_q == LOAD && beat) begin
                imem_we    <= 1'b1;
                imem_waddr <= cnt_q[AW-1:0];
                imem_wdata <= s_data;
                cnt_q      <= cnt_inc;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= DATA_WIDTH'(CSUM_SEED);
        end else if (state_q == LEN && beat) begin
            csum_q <= DATA_WIDTH'(CSUM_SEED);
        end else if (state_q == LOAD && beat) begin
            csum_q <= csum_q ^ s_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader (DATA_WIDTH=32, IMEM_SZ_IN_KB=1, DEPTH=256).
// Cycle table for the basic N=3 / N=0 / N=257 flows, then hand-written
// sequences for a full-depth load with random gaps, the checksum build
// (IMEM_LOADER_CHECKSUM_EN) and a reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DW    = 32;
    localparam int KB    = 1;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [DW-1:0] imem_wdata;
    logic          core_arst_n;
    logic          busy, done, err;
    state_e        dbg_state;

    imem_loader #(.DATA_WIDTH(DW), .IMEM_SZ_IN_KB(KB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_arst_n(core_arst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------------------------------------------------------- scoreboard
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    payload_q[$];
    bit               mon_en = 1'b0;
    int               wr_count = 0;
    logic [AW-1:0]    last_addr = '0;

    always @(negedge clk) begin
        if (mon_en && imem_we) begin
            wr_count++;
            last_addr = imem_waddr;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {imem_waddr, imem_wdata}, '0);
            end else begin
                chk("write", {imem_waddr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        wr_count = 0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk({name, "_state"}, dbg_state, IDLE);
        chk({name, "_outs"}, {s_ready, imem_we, imem_waddr, imem_wdata,
                              core_arst_n, busy, done, err}, '0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_word(input logic [DW-1:0] d, input int gap);
        bit ok;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!ok) fail_now("beat_accept");
    endtask

    // Length word, payload from payload_q, optional trailing checksum word.
    task automatic run_load(input int max_gap, input bit send_csum, input logic [DW-1:0] csum);
        pulse_start();
        send_word(DW'(payload_q.size()), $urandom_range(0, max_gap));
        for (int i = 0; i < payload_q.size(); i++) begin
            exp_q.push_back({AW'(i), payload_q[i]});
            send_word(payload_q[i], $urandom_range(0, max_gap));
        end
        if (send_csum) send_word(csum, 0);
    endtask

    task automatic wait_end(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = done || err;
        end
        if (!seen) fail_now("wait_done_or_err");
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] xor_payload();
        logic [DW-1:0] x = '0;
        foreach (payload_q[i]) x ^= payload_q[i];
        return x;
    endfunction

    // ---------------------------------------------------------------- vectors
    // flags = {s_ready, imem_we, core_arst_n, busy, done, err}
    typedef struct {
        logic          st;
        logic          vl;
        logic [DW-1:0] d;
        logic [5:0]    flags;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic vl, input logic [DW-1:0] d,
                                input logic [5:0] flags, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.flags = flags; v.a = a; v.wd = wd;
        return v;
    endfunction

    vec_t vecs[$];
    logic [DW-1:0] xo;

    initial begin
        // N=3 image, no gaps: writes land on three consecutive cycles.
        vecs.push_back(mk(1, 0, 32'h0,   6'b000000, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd3,   6'b100100, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h13,  6'b100100, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h93,  6'b110100, 8'd0, 32'h13));
        vecs.push_back(mk(0, 1, 32'h113, 6'b110100, 8'd1, 32'h93));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(0, 1, 32'h193, 6'b110100, 8'd2, 32'h113));
        vecs.push_back(mk(0, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
`else
        vecs.push_back(mk(0, 0, 32'h0,   6'b011010, 8'd2, 32'h113));
        vecs.push_back(mk(0, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
`endif
        // Restart from DONE with N=0: DONE again one cycle after the length.
        vecs.push_back(mk(1, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0,   6'b100100, 8'd0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
        // N=257 exceeds 256 words: ERR, no writes, further words refused.
        vecs.push_back(mk(1, 0, 32'h0,   6'b001010, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd257, 6'b100100, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h5,   6'b000001, 8'd0, 32'h0));
        // Restart from ERR goes back to LEN.
        vecs.push_back(mk(1, 0, 32'h0,   6'b000001, 8'd0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   6'b100100, 8'd0, 32'h0));

        // ---- reset state
        do_reset();
        check_idle("reset");

        // ---- table
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            start   = vecs[i].st;
            s_valid = vecs[i].vl;
            s_data  = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_flags", i),
                {s_ready, imem_we, core_arst_n, busy, done, err}, vecs[i].flags);
            if (vecs[i].flags[4])
                chk($sformatf("vec%0d_write", i), {imem_waddr, imem_wdata},
                    {vecs[i].a, vecs[i].wd});
        end
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b0;

        // ---- full-depth load with random valid gaps
        do_reset();
        mon_en = 1'b1;
        payload_q.delete();
        for (int i = 0; i < DEPTH; i++) payload_q.push_back($urandom);
        xo = xor_payload();
        run_load(2, 1'b0, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(xo, 1);
`endif
        wait_end(20);
        chk("full_done", {done, err, core_arst_n}, 3'b101);
        chk("full_wr_count", wr_count, DEPTH);
        chk("full_last_addr", last_addr, DEPTH - 1);
        chk("full_queue_empty", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- checksum good then bad
        do_reset();
        payload_q.delete();
        payload_q.push_back(32'h1);
        payload_q.push_back(32'h2);
        run_load(0, 1'b1, 32'h3);
        wait_end(10);
        chk("csum_good", {done, err, core_arst_n}, 3'b101);
        chk("csum_good_writes", wr_count, 2);
        run_load(0, 1'b1, 32'h4);
        wait_end(10);
        chk("csum_bad", {done, err, core_arst_n}, 3'b010);
        chk("csum_bad_writes", wr_count, 4);
`endif

        // ---- reset in the middle of a 4-word load, then reload
        do_reset();
        pulse_start();
        send_word(32'd4, 0);
        exp_q.push_back({8'd0, 32'hA0});
        send_word(32'hA0, 0);
        exp_q.push_back({8'd1, 32'hA1});
        send_word(32'hA1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_writes", wr_count, 2);
        check_idle("abort");
        chk("abort_no_write", imem_we, 1'b0);
        exp_q.delete();
        wr_count = 0;
        payload_q.delete();
        for (int i = 0; i < 4; i++) payload_q.push_back(32'hB0 + i);
        xo = xor_payload();
        run_load(1, 1'b0, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(xo, 0);
`endif
        wait_end(10);
        chk("reload_done", {done, err, core_arst_n}, 3'b101);
        chk("reload_writes", wr_count, 4);
        chk("reload_last_addr", last_addr, 3);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
